// File: rtl/clock_rate_controller_pkg.sv
// Shared clock-domain bundle and clks_alot engine definitions used by the clock sequencer.
package common_p;
    typedef struct packed {
        logic clk;
        logic reset;
    } clk_dom;
endpackage

package clks_alot_p;
    typedef enum logic [1:0] {
        CMD_START    = 2'd0,
        CMD_STOP     = 2'd1,
        CMD_SET_RATE = 2'd2
    } clock_cmd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        STOPPING = 2'd2
    } clock_state_e;

    localparam int MIN_HALF_PERIOD = 2;
endpackage

// File: rtl/clock_rate_controller_counter.sv
// Half-period counter: owns the active/pending rate registers and generates both strobes.
module half_period_counter #(
    parameter int                       COUNTER_WIDTH       = 16,
    parameter logic [COUNTER_WIDTH-1:0] DEFAULT_HALF_PERIOD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     load_now,
    input  logic                     load_pending,
    input  logic [COUNTER_WIDTH-1:0] rate,
    output logic                     half_elapsed,
    output logic                     quarter_elapsed
);
    localparam logic [COUNTER_WIDTH-1:0] ONE = 1;

    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH-1:0] active_rate;
    logic [COUNTER_WIDTH-1:0] pending_rate;
    logic                     pending_vld;

    // Gated by run so nothing strobes while the clock is parked.
    assign half_elapsed    = run && (count == active_rate - ONE);
    assign quarter_elapsed = run && (count == (active_rate >> 1) - ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            active_rate  <= DEFAULT_HALF_PERIOD;
            pending_rate <= '0;
            pending_vld  <= 1'b0;
        end else begin
            if (!run || half_elapsed) begin
                count <= '0;
            end else begin
                count <= count + ONE;
            end

            if (load_now) begin
                active_rate <= rate;
            end else if (half_elapsed && pending_vld) begin
                active_rate <= pending_rate;
            end

            // A command landing on the boundary cycle queues for the following boundary.
            if (half_elapsed) begin
                pending_vld <= 1'b0;
            end
            if (load_pending) begin
                pending_rate <= rate;
                pending_vld  <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/clock_rate_controller.sv
// Programmable I/O clock sequencer: start/stop/rate commands, parks io_clk at IDLE_LEVEL when stopped.
module clock_rate_controller
    import common_p::*;
    import clks_alot_p::*;
#(
    parameter int   COUNTER_WIDTH       = 16,
    parameter logic IDLE_LEVEL          = 1'b0,
    parameter int   DEFAULT_HALF_PERIOD = 4
) (
    input  clk_dom                   sys_dom_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  clock_cmd_e               cmd_op_i,
    input  logic [COUNTER_WIDTH-1:0] cmd_half_period_i,
    output logic                     cmd_error_o,
    output logic                     io_clk_o,
    output logic                     half_rate_elapsed_o,
    output logic                     quarter_rate_elapsed_o,
    output logic                     clock_active_o,
    output logic                     busy_o
);
    logic         clk;
    logic         rst;
    clock_state_e state;
    clock_state_e state_next;
    logic         io_clk;
    logic         io_clk_next;
    logic         cmd_error_next;
    logic         accept;
    logic         rate_ok;
    logic         run;
    logic         load_now;
    logic         load_pending;
    logic         half_elapsed;
    logic         quarter_elapsed;

    assign clk     = sys_dom_i.clk;
    assign rst     = sys_dom_i.reset;
    assign run     = (state != IDLE);
    assign accept  = cmd_valid_i && cmd_ready_o;
    assign rate_ok = (cmd_half_period_i >= COUNTER_WIDTH'(MIN_HALF_PERIOD));

    half_period_counter #(
        .COUNTER_WIDTH      (COUNTER_WIDTH),
        .DEFAULT_HALF_PERIOD(COUNTER_WIDTH'(DEFAULT_HALF_PERIOD))
    ) u_counter (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .load_now       (load_now),
        .load_pending   (load_pending),
        .rate           (cmd_half_period_i),
        .half_elapsed   (half_elapsed),
        .quarter_elapsed(quarter_elapsed)
    );

    always_comb begin
        state_next     = state;
        io_clk_next    = io_clk;
        cmd_error_next = 1'b0;
        load_now       = 1'b0;
        load_pending   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op_i)
                        CMD_START: begin
                            state_next  = RUNNING;
                            io_clk_next = IDLE_LEVEL;
                        end
                        CMD_SET_RATE: begin
                            load_now       = rate_ok;
                            cmd_error_next = !rate_ok;
                        end
                        default: cmd_error_next = 1'b1;
                    endcase
                end
            end
            RUNNING: begin
                if (half_elapsed) begin
                    io_clk_next = !io_clk;
                end
                if (accept) begin
                    case (cmd_op_i)
                        CMD_STOP:     state_next = STOPPING;
                        CMD_SET_RATE: begin
                            load_pending   = rate_ok;
                            cmd_error_next = !rate_ok;
                        end
                        default:      cmd_error_next = 1'b1;
                    endcase
                end
            end
            STOPPING: begin
                // Park only on a boundary that lands on IDLE_LEVEL; otherwise run one more half.
                if (half_elapsed) begin
                    if (io_clk != IDLE_LEVEL) begin
                        state_next  = IDLE;
                        io_clk_next = IDLE_LEVEL;
                    end else begin
                        io_clk_next = !io_clk;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            io_clk      <= IDLE_LEVEL;
            cmd_error_o <= 1'b0;
        end else begin
            state       <= state_next;
            io_clk      <= io_clk_next;
            cmd_error_o <= cmd_error_next;
        end
    end

    assign cmd_ready_o            = (state != STOPPING);
    assign io_clk_o               = io_clk;
    assign half_rate_elapsed_o    = half_elapsed;
    assign quarter_rate_elapsed_o = quarter_elapsed;
    assign clock_active_o         = run;
    assign busy_o                 = run;
endmodule

// File: tb/tb_clock_rate_controller.sv
// Bench for clock_rate_controller: directed scenarios plus random commands against a cycle reference model.
module tb_clock_rate_controller;
    import common_p::*;
    import clks_alot_p::*;

    localparam int   W        = 16;
    localparam logic IDLE_LVL = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    clk_dom     sys_dom;
    logic       cmd_valid;
    logic       cmd_ready;
    clock_cmd_e cmd_op;
    logic [W-1:0] cmd_hp;
    logic       cmd_error;
    logic       io_clk;
    logic       half_el;
    logic       quarter_el;
    logic       active;
    logic       busy;

    assign sys_dom = {clk, rst};

    clock_rate_controller #(
        .COUNTER_WIDTH      (W),
        .IDLE_LEVEL         (IDLE_LVL),
        .DEFAULT_HALF_PERIOD(4)
    ) dut (
        .sys_dom_i             (sys_dom),
        .cmd_valid_i           (cmd_valid),
        .cmd_ready_o           (cmd_ready),
        .cmd_op_i              (cmd_op),
        .cmd_half_period_i     (cmd_hp),
        .cmd_error_o           (cmd_error),
        .io_clk_o              (io_clk),
        .half_rate_elapsed_o   (half_el),
        .quarter_rate_elapsed_o(quarter_el),
        .clock_active_o        (active),
        .busy_o                (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: clock running?, stop requested?, position in half period, rates
    bit m_active, m_stop, m_io, m_err, m_pend_v;
    int m_cnt, m_h, m_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_active = 0; m_stop = 0; m_io = IDLE_LVL; m_err = 0;
        m_pend_v = 0; m_cnt = 0; m_h = 4; m_pend = 0;
    endtask

    task automatic compare_all();
        check("io_clk",  32'(io_clk),     32'(m_io));
        check("half",    32'(half_el),    32'(m_active && (m_cnt == m_h - 1)));
        check("quarter", 32'(quarter_el), 32'(m_active && (m_cnt == m_h / 2 - 1)));
        check("active",  32'(active),     32'(m_active));
        check("busy",    32'(busy),       32'(m_active));
        check("ready",   32'(cmd_ready),  32'(!m_stop));
        check("error",   32'(cmd_error),  32'(m_err));
    endtask

    task automatic model_step();
        bit acc, half, n_err;
        acc   = cmd_valid && !m_stop;
        half  = m_active && (m_cnt == m_h - 1);
        n_err = 0;
        if (!m_active) begin
            if (acc) begin
                if (cmd_op == CMD_START) begin
                    m_active = 1; m_cnt = 0; m_io = IDLE_LVL;
                end else if (cmd_op == CMD_SET_RATE && cmd_hp >= 16'd2) begin
                    m_h = int'(cmd_hp);
                end else begin
                    n_err = 1;
                end
            end
        end else begin
            if (half) begin
                m_cnt = 0;
                if (m_pend_v) begin m_h = m_pend; m_pend_v = 0; end
                if (m_stop && m_io != IDLE_LVL) begin
                    m_active = 0; m_stop = 0; m_io = IDLE_LVL;
                end else begin
                    m_io = !m_io;
                end
            end else begin
                m_cnt++;
            end
            if (acc) begin
                if (cmd_op == CMD_STOP) m_stop = 1;
                else if (cmd_op == CMD_SET_RATE && cmd_hp >= 16'd2) begin
                    m_pend = int'(cmd_hp); m_pend_v = 1;
                end else n_err = 1;
            end
        end
        m_err = n_err;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input clock_cmd_e op, input logic [W-1:0] hp);
        cmd_valid = 1'b1; cmd_op = op; cmd_hp = hp;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_toggle(output int n);
        logic start_io;
        start_io = io_clk;
        n = 0;
        while (io_clk === start_io && n < 100) begin
            cycle();
            n++;
        end
        if (n >= 100) check("toggle_timeout", 32'(io_clk), 32'(!start_io));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cmd_valid = 1'b0; cmd_op = CMD_START; cmd_hp = '0;
        m_reset();

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready",  32'(cmd_ready), 32'd1);
        check("rst_io",     32'(io_clk),    32'd0);
        check("rst_active", 32'(active),    32'd0);
        check("rst_error",  32'(cmd_error), 32'd0);

        // START with H=4: quarter T+2, half T+4, rise T+5, fall T+9
        send(CMD_START, '0);
        check("start_active", 32'(active), 32'd1);
        check("start_io",     32'(io_clk), 32'd0);
        idle(1);
        check("start_quarter", 32'(quarter_el), 32'd1);
        idle(2);
        check("start_half", 32'(half_el), 32'd1);
        idle(1);
        check("start_rise", 32'(io_clk), 32'd1);
        idle(4);
        check("start_fall", 32'(io_clk), 32'd0);

        // Two SET_RATEs in one half period: the later one wins
        send(CMD_SET_RATE, 16'd6);
        send(CMD_SET_RATE, 16'd8);
        wait_toggle(n);
        check("cur_half_kept", 32'(n), 32'd2);
        wait_toggle(n);
        check("overwrite_len", 32'(n), 32'd8);
        send(CMD_SET_RATE, 16'd6);
        wait_toggle(n);
        wait_toggle(n);
        check("rate6_len", 32'(n), 32'd6);
        idle(2);
        check("rate6_quarter", 32'(quarter_el), 32'd1);
        send(CMD_SET_RATE, 16'd4);
        wait_toggle(n);
        wait_toggle(n);
        check("rate4_len", 32'(n), 32'd4);

        // STOP while high: parks at next boundary
        while (io_clk !== 1'b1) wait_toggle(n);
        send(CMD_STOP, '0);
        check("stop_ready", 32'(cmd_ready), 32'd0);
        wait_toggle(n);
        check("stop_hi_len",    32'(n),         32'd3);
        check("stop_hi_active", 32'(active),    32'd0);
        check("stop_hi_busy",   32'(busy),      32'd0);
        check("stop_hi_ready",  32'(cmd_ready), 32'd1);

        // STOP while low: one extra high half, then park
        send(CMD_START, '0);
        send(CMD_STOP, '0);
        n = 0;
        while (active === 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        check("stop_lo_elapsed", 32'(n + 1), 32'd8);
        check("stop_lo_io",      32'(io_clk), 32'd0);

        // Illegal commands
        send(CMD_STOP, '0);
        check("err_stop_idle", 32'(cmd_error), 32'd1);
        check("err_stop_busy", 32'(busy),      32'd0);
        send(CMD_SET_RATE, 16'd1);
        check("err_rate1", 32'(cmd_error), 32'd1);
        send(CMD_START, '0);
        check("start_ok_err", 32'(cmd_error), 32'd0);
        send(CMD_START, '0);
        check("err_start_run", 32'(cmd_error), 32'd1);
        check("err_start_busy", 32'(busy),     32'd1);
        send(CMD_SET_RATE, 16'd0);
        check("err_rate0", 32'(cmd_error), 32'd1);
        wait_toggle(n);
        wait_toggle(n);
        check("rate_unchanged", 32'(n), 32'd4);

        // Async reset at counter 2 with a pending rate
        wait_toggle(n);
        send(CMD_SET_RATE, 16'd6);
        idle(1);
        rst = 1'b1;
        #1;
        check("arst_active",  32'(active),     32'd0);
        check("arst_busy",    32'(busy),       32'd0);
        check("arst_io",      32'(io_clk),     32'd0);
        check("arst_ready",   32'(cmd_ready),  32'd1);
        check("arst_half",    32'(half_el),    32'd0);
        check("arst_quarter", 32'(quarter_el), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
        send(CMD_START, '0);
        wait_toggle(n);
        check("arst_first_half", 32'(n), 32'd4);
        wait_toggle(n);
        check("arst_default", 32'(n), 32'd4);

        // Random commands against the model
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = clock_cmd_e'($urandom_range(0, 2));
            cmd_hp    = W'($urandom_range(0, 9));
            cycle();
        end
        cmd_valid = 1'b0;
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
